// File: rtl/led_fade_pkg.sv
// led_fade_pkg: shared width defaults and the saturating fade step
package led_fade_pkg;
  localparam int DEF_PWM_BITS = 8;
  localparam int PWM_MAX = 2**DEF_PWM_BITS - 1;
  function automatic int sat_step(input int level, input int target, input int inc);
    return level < target ? (target - level <= inc ? target : level + inc)
                          : (level - target <= inc ? target : level - inc);
  endfunction
endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED's fade level register and registered PWM compare
import led_fade_pkg::*;
module led_fade_channel #(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int FADE_INC = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tgt,
  input  logic                fade_en,
  input  logic                period_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pin,
  output logic                neq
);
  localparam logic [PWM_BITS-1:0] lvl_max = '1;
  logic [PWM_BITS-1:0] level, target, level_d;
  always_comb begin
    target = tgt ? lvl_max : '0;
    level_d = !fade_en ? target
            : period_tick ? PWM_BITS'(sat_step(int'(level), int'(target), FADE_INC))
            : level;
    neq = fade_en && level != target;
  end
  always_ff @(posedge clk)
    if (reset) begin
      level <= '0;
      pin <= 1'b0;
    end else begin
      level <= level_d;
      pin <= level == lvl_max || (level != '0 && pwm_cnt < level);
    end
endmodule

// File: rtl/led_fade_driver.sv
// led_fade_driver: PWM LED driver with optional linear fade per LED
import led_fade_pkg::*;
module led_fade_driver #(
  parameter int N_LEDS   = 8,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int PRESCALE = 50,
  parameter int FADE_INC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] led_word,
  input  logic              fade_en,
  output logic [N_LEDS-1:0] led_pins,
  output logic              busy
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [N_LEDS-1:0] word_q, neq;
  logic [PW-1:0] presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic pwm_tick, period_tick;
  assign pwm_tick = presc == PW'(PRESCALE - 1);
  assign period_tick = pwm_tick && pwm_cnt == '1;
  always_ff @(posedge clk)
    if (reset) begin
      word_q <= '0;
      presc <= '0;
      pwm_cnt <= '0;
      busy <= 1'b0;
    end else begin
      word_q <= led_word;
      presc <= pwm_tick ? '0 : presc + PW'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(pwm_tick);
      busy <= |neq;
    end
  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_fade_channel #(.PWM_BITS(PWM_BITS), .FADE_INC(FADE_INC)) u_ch (
      .clk(clk),
      .reset(reset),
      .tgt(word_q[i]),
      .fade_en(fade_en),
      .period_tick(period_tick),
      .pwm_cnt(pwm_cnt),
      .pin(led_pins[i]),
      .neq(neq[i])
    );
  end
endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver: directed self-checking bench for led_fade_driver
module tb_led_fade_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] led_word = 8'hFF;
  logic fade_en = 1'b1;
  logic [7:0] led_pins;
  logic busy;
  int checks = 0;
  int failures = 0;
  int ph = 0;
  led_fade_driver #(.N_LEDS(8), .PWM_BITS(4), .PRESCALE(2), .FADE_INC(4)) dut (
    .clk(clk),
    .reset(reset),
    .led_word(led_word),
    .fade_en(fade_en),
    .led_pins(led_pins),
    .busy(busy)
  );
  wire [3:0] lvl0 = dut.g_ch[0].u_ch.level;
  always #5 clk = ~clk;
  always @(posedge clk) ph <= reset ? 0 : ph + 1;
  task automatic wait_tick;
    do @(negedge clk); while (ph % 32 != 0);
  endtask
  task automatic snap_zero_then_fade;
    fade_en = 1'b0;
    led_word = 8'h00;
    repeat (3) @(negedge clk);
    fade_en = 1'b1;
    led_word = 8'h01;
    repeat (2) @(negedge clk);
    wait_tick;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (led_pins !== 8'h00 || busy !== 1'b0 || lvl0 !== 4'd0) begin
        failures++;
        $display("FAIL reset cyc%0d pins=%h busy=%b lvl=%0d want 00/0/0", i, led_pins, busy, lvl0);
      end
    end
    reset = 1'b0;
    led_word = 8'h00;
    fade_en = 1'b0;
  endtask
  task automatic test_snap;
    repeat (3) @(negedge clk);
    led_word = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (led_pins !== 8'h00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL snap_latency cyc%0d pins=%h busy=%b want 00/0", i, led_pins, busy);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (led_pins !== 8'hA5 || busy !== 1'b0) begin
        failures++;
        $display("FAIL snap_steady cyc%0d pins=%h busy=%b want a5/0", i, led_pins, busy);
      end
    end
  endtask
  task automatic test_fade_up;
    int hi = 0;
    snap_zero_then_fade;
    checks++;
    if (lvl0 !== 4'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL up_step1 lvl=%0d busy=%b want 4/1", lvl0, busy);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      hi += int'(led_pins[0]);
    end
    checks++;
    if (hi != 8) begin
      failures++;
      $display("FAIL up_duty high_clks=%0d want 8", hi);
    end
    checks++;
    if (lvl0 !== 4'd8) begin
      failures++;
      $display("FAIL up_step2 lvl=%0d want 8", lvl0);
    end
    wait_tick;
    checks++;
    if (lvl0 !== 4'd12 || busy !== 1'b1) begin
      failures++;
      $display("FAIL up_step3 lvl=%0d busy=%b want 12/1", lvl0, busy);
    end
    wait_tick;
    checks++;
    if (lvl0 !== 4'd15 || busy !== 1'b1) begin
      failures++;
      $display("FAIL up_step4 lvl=%0d busy=%b want 15/1", lvl0, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL up_busy_fall busy=%b want 0", busy);
    end
  endtask
  task automatic test_reverse;
    snap_zero_then_fade;
    wait_tick;
    checks++;
    if (lvl0 !== 4'd8) begin
      failures++;
      $display("FAIL rev_start lvl=%0d want 8", lvl0);
    end
    led_word = 8'h00;
    wait_tick;
    checks++;
    if (lvl0 !== 4'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rev_step1 lvl=%0d busy=%b want 4/1", lvl0, busy);
    end
    wait_tick;
    checks++;
    if (lvl0 !== 4'd0) begin
      failures++;
      $display("FAIL rev_step2 lvl=%0d want 0", lvl0);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rev_busy busy=%b want 0", busy);
    end
  endtask
  task automatic test_fade_off;
    snap_zero_then_fade;
    checks++;
    if (lvl0 !== 4'd4) begin
      failures++;
      $display("FAIL off_start lvl=%0d want 4", lvl0);
    end
    fade_en = 1'b0;
    @(negedge clk);
    checks++;
    if (lvl0 !== 4'd15 || busy !== 1'b0) begin
      failures++;
      $display("FAIL off_snap lvl=%0d busy=%b want 15/0", lvl0, busy);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (led_pins !== 8'h01 || busy !== 1'b0) begin
        failures++;
        $display("FAIL off_steady cyc%0d pins=%h busy=%b want 01/0", i, led_pins, busy);
      end
    end
  endtask
  task automatic test_reset_mid;
    snap_zero_then_fade;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (led_pins !== 8'h00 || busy !== 1'b0 || lvl0 !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset pins=%h busy=%b lvl=%0d want 00/0/0", led_pins, busy, lvl0);
    end
    reset = 1'b0;
    do @(negedge clk); while (ph < 31);
    checks++;
    if (lvl0 !== 4'd0) begin
      failures++;
      $display("FAIL restart_hold lvl=%0d want 0", lvl0);
    end
    @(negedge clk);
    checks++;
    if (lvl0 !== 4'd4) begin
      failures++;
      $display("FAIL restart_step lvl=%0d want 4", lvl0);
    end
  endtask
  initial begin
    test_reset;
    test_snap;
    test_fade_up;
    test_reverse;
    test_fade_off;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
